// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Two-requester register-file writeback arbiter. Requester A (ALU) has
//   priority; requester B (load) is guaranteed a grant once it has watched
//   STARVE_LIMIT consecutive A grants. The granted write is registered and
//   presented to the register file one cycle after the transfer. Writes to
//   x0 are accepted but never reach the register file.
//
//   Optional feature (compile-time macro WB_FWD_EN): write-to-read bypass.
//   The registered write is forwarded onto RS1_OUT/RS2_OUT when its address
//   matches the read address (x0 excluded). Without the macro the read data
//   passes straight through.
//
// Ports
//   CLK, RST                   clock, synchronous active-high reset
//   HOLD                       pipeline freeze, suppresses all grants
//   A_VALID/A_ADDR/A_DATA      requester A write, A_READY = accepted
//   B_VALID/B_ADDR/B_DATA      requester B write, B_READY = accepted
//   W_EN/W_ADDR/W_DATA         registered register-file write port
//   RADDR1/RADDR2              register-file read addresses
//   RS1_IN/RS2_IN              raw register-file read data
//   RS1_OUT/RS2_OUT            read data delivered to the datapath

module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HOLD,
  input  logic        A_VALID,
  input  logic [4:0]  A_ADDR,
  input  logic [31:0] A_DATA,
  output logic        A_READY,
  input  logic        B_VALID,
  input  logic [4:0]  B_ADDR,
  input  logic [31:0] B_DATA,
  output logic        B_READY,
  output logic        W_EN,
  output logic [4:0]  W_ADDR,
  output logic [31:0] W_DATA,
  input  logic [4:0]  RADDR1,
  input  logic [4:0]  RADDR2,
  input  logic [31:0] RS1_IN,
  input  logic [31:0] RS2_IN,
  output logic [31:0] RS1_OUT,
  output logic [31:0] RS2_OUT
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        w_en_q, w_en_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;

  logic        grant_ok;
  logic        b_starved;
  logic        a_gnt, b_gnt;

  // Grants are suppressed during reset so a write presented in a reset
  // cycle is never handshaken.
  assign grant_ok  = !RST && !HOLD;
  assign b_starved = B_VALID && (starve_q == LIMIT);
  assign a_gnt     = grant_ok && A_VALID && !b_starved;
  assign b_gnt     = grant_ok && B_VALID && (!A_VALID || b_starved);

  assign A_READY = a_gnt;
  assign B_READY = b_gnt;

  always_comb begin
    starve_d = starve_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;

    if (!HOLD) begin
      // The counter only tracks a B that is actually waiting; it can never
      // pass LIMIT because B wins the cycle it reaches LIMIT.
      if (b_gnt || !B_VALID) begin
        starve_d = 4'd0;
      end else if (a_gnt) begin
        starve_d = starve_q + 4'd1;
      end
    end

    if (a_gnt) begin
      w_en_d   = (A_ADDR != 5'd0);
      w_addr_d = A_ADDR;
      w_data_d = A_DATA;
    end else if (b_gnt) begin
      w_en_d   = (B_ADDR != 5'd0);
      w_addr_d = B_ADDR;
      w_data_d = B_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= 4'd0;
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign W_EN   = w_en_q;
  assign W_ADDR = w_addr_q;
  assign W_DATA = w_data_q;

`ifdef WB_FWD_EN
  logic fwd1, fwd2;

  assign fwd1    = w_en_q && (w_addr_q == RADDR1) && (RADDR1 != 5'd0);
  assign fwd2    = w_en_q && (w_addr_q == RADDR2) && (RADDR2 != 5'd0);
  assign RS1_OUT = fwd1 ? w_data_q : RS1_IN;
  assign RS2_OUT = fwd2 ? w_data_q : RS2_IN;
`else
  logic unused_raddr;

  assign unused_raddr = ^{RADDR1, RADDR2};
  assign RS1_OUT      = RS1_IN;
  assign RS2_OUT      = RS2_IN;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST, HOLD;
  logic        A_VALID, B_VALID;
  logic [4:0]  A_ADDR, B_ADDR;
  logic [31:0] A_DATA, B_DATA;
  logic        A_READY, B_READY;
  logic        W_EN;
  logic [4:0]  W_ADDR;
  logic [31:0] W_DATA;
  logic [4:0]  RADDR1, RADDR2;
  logic [31:0] RS1_IN, RS2_IN, RS1_OUT, RS2_OUT;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST), .HOLD(HOLD),
    .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .RADDR1(RADDR1), .RADDR2(RADDR2), .RS1_IN(RS1_IN), .RS2_IN(RS2_IN),
    .RS1_OUT(RS1_OUT), .RS2_OUT(RS2_OUT)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: how many A grants B has sat through, plus the write
  // the register file should see next cycle.
  int          m_waited = 0;
  logic        m_wen    = 1'b0;
  logic [4:0]  m_waddr  = '0;
  logic [31:0] m_wdata  = '0;
  logic        obs_a, obs_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_exp(input logic [4:0] ra, input logic [31:0] raw);
`ifdef WB_FWD_EN
    if (m_wen && m_waddr == ra && ra != 0) return m_wdata;
`endif
    return raw;
  endfunction

  // One clock cycle with the inputs currently driven: check handshake and
  // read path mid-cycle, then the registered write port after the edge.
  task automatic step();
    logic ea, eb;
    ea = 1'b0;
    eb = 1'b0;
    #1;
    if (!RST && !HOLD) begin
      if (A_VALID && !(B_VALID && m_waited == LIMIT)) ea = 1'b1;
      else if (B_VALID) eb = 1'b1;
    end
    obs_a = A_READY;
    obs_b = B_READY;
    chk("a_ready", 32'(A_READY), 32'(ea));
    chk("b_ready", 32'(B_READY), 32'(eb));
    chk("rs1_out", RS1_OUT, rd_exp(RADDR1, RS1_IN));
    chk("rs2_out", RS2_OUT, rd_exp(RADDR2, RS2_IN));
    @(posedge CLK);
    #1;
    if (RST) begin
      m_waited = 0;
      m_wen = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      m_wen = 0;
      if (ea) begin
        m_wen = (A_ADDR != 0); m_waddr = A_ADDR; m_wdata = A_DATA;
      end else if (eb) begin
        m_wen = (B_ADDR != 0); m_waddr = B_ADDR; m_wdata = B_DATA;
      end
      if (!HOLD) begin
        if (!B_VALID || eb) m_waited = 0;
        else if (ea) m_waited++;
      end
    end
    chk("w_en", 32'(W_EN), 32'(m_wen));
    if (m_wen || RST) begin
      chk("w_addr", 32'(W_ADDR), 32'(m_waddr));
      chk("w_data", W_DATA, m_wdata);
    end
  endtask

  initial begin
    RST = 1; HOLD = 0;
    A_VALID = 1; A_ADDR = 5'd3; A_DATA = 32'h1111_2222;
    B_VALID = 0; B_ADDR = 5'd4; B_DATA = 32'h3333_4444;
    RADDR1 = 0; RADDR2 = 0; RS1_IN = 32'h0BAD_F00D; RS2_IN = 32'h600D_CAFE;
    @(posedge CLK); #1;
    step();
    step();
    chk("reset_wen", 32'(W_EN), 32'd0);
    chk("reset_wdata", W_DATA, 32'd0);

    // A only
    RST = 0;
    A_VALID = 1; A_ADDR = 5'd5; A_DATA = 32'hDEAD_BEEF; B_VALID = 0;
    step();
    chk("aonly_ready", 32'(obs_a), 32'd1);
    chk("aonly_wen", 32'(W_EN), 32'd1);
    chk("aonly_waddr", 32'(W_ADDR), 32'd5);
    chk("aonly_wdata", W_DATA, 32'hDEAD_BEEF);

    // Starvation: 4 A grants, B on the 5th, then A again
    A_VALID = 1; B_VALID = 1; B_ADDR = 5'd6;
    for (int i = 0; i < 6; i++) begin
      A_DATA = 32'hA000_0000 + 32'(i);
      B_DATA = 32'hB000_0000 + 32'(i);
      step();
      chk("starve_seq", {30'd0, obs_a, obs_b}, (i == 4) ? 32'd1 : 32'd2);
    end

    // HOLD mid-count: count must survive the freeze
    step();
    HOLD = 1;
    step();
    chk("hold_grants", {30'd0, obs_a, obs_b}, 32'd0);
    step();
    chk("hold_wen", 32'(W_EN), 32'd0);
    HOLD = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_resume", {30'd0, obs_a, obs_b}, (i == 2) ? 32'd1 : 32'd2);
    end

    // x0 discard on B
    A_VALID = 0; B_VALID = 1; B_ADDR = 5'd0; B_DATA = 32'h0000_1234;
    step();
    chk("x0_ready", 32'(obs_b), 32'd1);
    chk("x0_wen", 32'(W_EN), 32'd0);

    // Reset right after an A grant
    B_VALID = 0; A_VALID = 1; A_ADDR = 5'd9; A_DATA = 32'h5555_AAAA;
    step();
    RST = 1;
    step();
    chk("rst_after_wen", 32'(W_EN), 32'd0);
    chk("rst_after_wdata", W_DATA, 32'd0);
    RST = 0;

    // Bypass
    A_VALID = 1; A_ADDR = 5'd7; A_DATA = 32'hA5A5_A5A5;
    step();
    A_VALID = 0;
    RADDR1 = 5'd7; RS1_IN = 32'h0;
    RADDR2 = 5'd0; RS2_IN = 32'h1357_9BDF;
    #1;
`ifdef WB_FWD_EN
    chk("byp_rs1", RS1_OUT, 32'hA5A5_A5A5);
`else
    chk("byp_rs1", RS1_OUT, 32'h0);
`endif
    chk("byp_rs2", RS2_OUT, 32'h1357_9BDF);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      RST     = ($urandom % 40) == 0;
      HOLD    = ($urandom % 8) == 0;
      A_VALID = ($urandom % 4) != 0;
      B_VALID = ($urandom % 4) != 0;
      A_ADDR  = 5'($urandom % 8);
      B_ADDR  = 5'($urandom % 8);
      A_DATA  = $urandom;
      B_DATA  = $urandom;
      RADDR1  = 5'($urandom % 8);
      RADDR2  = 5'($urandom % 8);
      RS1_IN  = $urandom;
      RS2_IN  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
